serializador_cuenta: RTL

// - Etapa aguas abajo del contador de 4 bits: recibe cada valor de cuenta y lo transmite por una línea serie.
// - Trama de estilo UART: bit de inicio, datos LSB primero y bit de parada; línea en reposo a 1.
// - Handshake valido/listo para no perder ni duplicar valores; permite ver la cuenta en un pin externo o en el bench.

---
 rtl/serializador_cuenta_pkg.sv | 20 ++
 rtl/serializador_cuenta_generador_tick_bit.sv | 32 +++
 rtl/serializador_cuenta.sv | 132 +++++++++++++
 3 files changed

// File: rtl/serializador_cuenta_pkg.sv
// Shared definitions for the serializador_cuenta UART-style serializer.
// State encoding: REPOSO=0, INICIO=1, DATOS=2, PARIDAD=3, PARADA=4 (3-bit register).
package serializador_cuenta_pkg;

    localparam int ANCHO_ESTADO = 3;

    typedef enum logic [ANCHO_ESTADO-1:0] {
        REPOSO  = 3'd0,
        INICIO  = 3'd1,
        DATOS   = 3'd2,
        PARIDAD = 3'd3,
        PARADA  = 3'd4
    } estado_t;

    // Width needed to count 0..n-1, never below one bit.
    function automatic int ancho_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializador_cuenta_generador_tick_bit.sv
// Bit-period timer: pulses o_fin_bit on the last clock of every bit slot
// while enabled, and holds its cycle counter at zero when disabled.
module generador_tick_bit
    import serializador_cuenta_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_habilita,
    output logic o_fin_bit
);

    localparam int CW = ancho_min1(CICLOS_POR_BIT);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_POR_BIT - 1);

    logic [CW-1:0] ciclo_q;

    // Cycle counter inside the current bit, wraps to zero at the end of each bit.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_habilita) begin
            ciclo_q <= '0;
        end else if (ciclo_q == ULTIMO) begin
            ciclo_q <= '0;
        end else begin
            ciclo_q <= ciclo_q + CW'(1);
        end
    end

    assign o_fin_bit = i_habilita && (ciclo_q == ULTIMO);

endmodule

// File: rtl/serializador_cuenta.sv
// UART-style serializer for the 4-bit counter: start bit, ANCHO data bits
// LSB first, optional even parity bit, stop bit; idle line is high.
// Optional feature: define SERIALIZADOR_PARIDAD_EN to insert the parity bit.
module serializador_cuenta
    import serializador_cuenta_pkg::*;
#(
    parameter int ANCHO          = 4,
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ANCHO-1:0] i_cuenta,
    input  logic             i_valido,
    output logic             o_listo,
    output logic             o_tx,
    output logic             o_ocupado
);

    localparam int IW = ancho_min1(ANCHO);
    localparam logic [IW-1:0] ULTIMO_BIT = IW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic [IW-1:0]    indice_q, indice_d;
    logic             tx_q, tx_d;
    logic             fin_bit;
`ifdef SERIALIZADOR_PARIDAD_EN
    logic             paridad_q, paridad_d;
`endif

    generador_tick_bit #(
        .CICLOS_POR_BIT (CICLOS_POR_BIT)
    ) u_tick (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_habilita (estado_q != REPOSO),
        .o_fin_bit  (fin_bit)
    );

    // Next state, shift register, bit index and next line level.
    always_comb begin
        estado_d = estado_q;
        dato_d   = dato_q;
        indice_d = indice_q;
        tx_d     = tx_q;
`ifdef SERIALIZADOR_PARIDAD_EN
        paridad_d = paridad_q;
`endif
        case (estado_q)
            REPOSO: begin
                tx_d = 1'b1;
                if (i_valido) begin
                    estado_d = INICIO;
                    tx_d     = 1'b0;
                    dato_d   = i_cuenta;
                    indice_d = '0;
`ifdef SERIALIZADOR_PARIDAD_EN
                    paridad_d = ^i_cuenta;
`endif
                end
            end
            INICIO: begin
                if (fin_bit) begin
                    estado_d = DATOS;
                    tx_d     = dato_q[0];
                    dato_d   = dato_q >> 1;
                end
            end
            DATOS: begin
                if (fin_bit) begin
                    if (indice_q == ULTIMO_BIT) begin
`ifdef SERIALIZADOR_PARIDAD_EN
                        estado_d = PARIDAD;
                        tx_d     = paridad_q;
`else
                        estado_d = PARADA;
                        tx_d     = 1'b1;
`endif
                    end else begin
                        indice_d = indice_q + IW'(1);
                        tx_d     = dato_q[0];
                        dato_d   = dato_q >> 1;
                    end
                end
            end
`ifdef SERIALIZADOR_PARIDAD_EN
            PARIDAD: begin
                if (fin_bit) begin
                    estado_d = PARADA;
                    tx_d     = 1'b1;
                end
            end
`endif
            PARADA: begin
                if (fin_bit) begin
                    estado_d = REPOSO;
                    tx_d     = 1'b1;
                end
            end
            default: begin
                estado_d = REPOSO;
                tx_d     = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            estado_q <= REPOSO;
            dato_q   <= '0;
            indice_q <= '0;
            tx_q     <= 1'b1;
`ifdef SERIALIZADOR_PARIDAD_EN
            paridad_q <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            dato_q   <= dato_d;
            indice_q <= indice_d;
            tx_q     <= tx_d;
`ifdef SERIALIZADOR_PARIDAD_EN
            paridad_q <= paridad_d;
`endif
        end
    end

    assign o_tx      = tx_q;
    assign o_ocupado = (estado_q != REPOSO);
    assign o_listo   = (estado_q == REPOSO) && !i_rst;

endmodule
